// File: rtl/espectro_rx_if.sv
`default_nettype none
// ============================================================================
// Module  : espectro_rx_if
// Brief   : Run control, serial line and status bundle of the tone-link receiver.
// Rev     : 1.0  initial release
// ============================================================================
interface espectro_rx_if;
   logic        enable;
   logic [31:0] fr;
   logic        din;
   logic        bit_strobe;
   logic        match;
   logic        locked;
   logic [15:0] match_count;

   modport master (
      output enable, fr, din,
      input  bit_strobe, match, locked, match_count
   );

   modport slave (
      input  enable, fr, din,
      output bit_strobe, match, locked, match_count
   );
endinterface
`default_nettype wire

// File: rtl/espectro_rx.sv
`default_nettype none
// ============================================================================
// Module  : espectro_rx
// Brief   : Serial pattern detector / frame-lock receiver for the espectro link.
// Rev     : 1.0  initial release
// ============================================================================
module espectro_rx #(
   parameter int                 PAT_LEN  = 49,
   parameter logic [PAT_LEN-1:0] PATTERN  = 49'b0101101111111111111101101010010000000000000100010,
   parameter int                 MISS_MAX = 2
) (
   input  logic         clk50,
   input  logic         rst,
   espectro_rx_if.slave rx_if
);

   localparam int                c_MW       = $clog2(MISS_MAX + 1);
   localparam logic [5:0]        c_PL       = 6'(PAT_LEN);
   localparam logic [5:0]        c_LAST     = 6'(PAT_LEN - 1);
   localparam logic [c_MW-1:0]   c_MISS_LIM = c_MW'(MISS_MAX);

   localparam logic [0:0] S_HUNT   = 1'b0;
   localparam logic [0:0] S_LOCKED = 1'b1;

   logic                r_sync1;
   logic                r_din_s;
   logic                r_din_q;
   logic [31:0]         r_hcnt;
   logic                r_phase;
   logic [PAT_LEN-2:0]  r_sreg;
   logic [5:0]          r_vcnt;
   logic [5:0]          r_bidx;
   logic [c_MW-1:0]     r_miss;
   logic [0:0]          r_state;
   logic                r_bit_strobe;
   logic                r_match;
   logic [15:0]         r_match_count;

   logic                w_edge;
   logic                w_hit;
   logic                w_sample;
   logic [PAT_LEN-1:0]  w_window;
   logic [5:0]          w_vcnt_nxt;
   logic                w_pat_eq;
   logic [c_MW-1:0]     w_miss_nxt;

   assign w_edge     = r_din_s ^ r_din_q;
   assign w_hit      = (r_hcnt >= rx_if.fr);
   assign w_sample   = ~r_phase & w_hit & ~w_edge;
   // The oldest bit is never stored: the window is the 48-bit history plus the bit being sampled.
   assign w_window   = {r_sreg, r_din_s};
   assign w_vcnt_nxt = (r_vcnt == c_PL) ? r_vcnt : r_vcnt + 6'd1;
   assign w_pat_eq   = (w_window == PATTERN);
   assign w_miss_nxt = r_miss + c_MW'(1);

   always_ff @(posedge clk50) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_din_s <= 1'b0;
         r_din_q <= 1'b0;
      end else begin
         r_sync1 <= rx_if.din;
         r_din_s <= r_sync1;
         r_din_q <= r_din_s;
      end
   end

   always_ff @(posedge clk50) begin
      if (rst) begin
         r_hcnt        <= 32'd0;
         r_phase       <= 1'b0;
         r_sreg        <= '0;
         r_vcnt        <= 6'd0;
         r_bidx        <= 6'd0;
         r_miss        <= '0;
         r_state       <= S_HUNT;
         r_bit_strobe  <= 1'b0;
         r_match       <= 1'b0;
         r_match_count <= 16'd0;
      end else begin
         if (r_match && (r_match_count != 16'hFFFF))
            r_match_count <= r_match_count + 16'd1;

         if (!rx_if.enable) begin
            r_hcnt       <= 32'd0;
            r_phase      <= 1'b0;
            r_sreg       <= '0;
            r_vcnt       <= 6'd0;
            r_bidx       <= 6'd0;
            r_miss       <= '0;
            r_state      <= S_HUNT;
            r_bit_strobe <= 1'b0;
            r_match      <= 1'b0;
         end else begin
            r_bit_strobe <= w_sample;
            r_match      <= 1'b0;

            // Resync on an edge beats both the wrap and a coincident sample point.
            if (w_edge) begin
               r_hcnt  <= 32'd0;
               r_phase <= 1'b0;
            end else if (w_hit) begin
               r_hcnt  <= 32'd0;
               r_phase <= ~r_phase;
            end else begin
               r_hcnt  <= r_hcnt + 32'd1;
            end

            if (w_sample) begin
               r_sreg <= w_window[PAT_LEN-2:0];
               r_vcnt <= w_vcnt_nxt;
               if (r_state == S_HUNT) begin
                  if ((w_vcnt_nxt == c_PL) && w_pat_eq) begin
                     r_match <= 1'b1;
                     r_bidx  <= 6'd0;
                     r_miss  <= '0;
                     r_state <= S_LOCKED;
                  end
               end else if (r_bidx == c_LAST) begin
                  r_bidx <= 6'd0;
                  if (w_pat_eq) begin
                     r_match <= 1'b1;
                     r_miss  <= '0;
                  end else if (w_miss_nxt >= c_MISS_LIM) begin
                     // Forget history so relock needs a whole fresh frame.
                     r_miss  <= '0;
                     r_vcnt  <= 6'd0;
                     r_state <= S_HUNT;
                  end else begin
                     r_miss  <= w_miss_nxt;
                  end
               end else begin
                  r_bidx <= r_bidx + 6'd1;
               end
            end
         end
      end
   end

   assign rx_if.bit_strobe  = r_bit_strobe;
   assign rx_if.match       = r_match;
   assign rx_if.locked      = (r_state == S_LOCKED);
   assign rx_if.match_count = r_match_count;

endmodule
`default_nettype wire
